game_ctrl: RTL
==============

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter ROUND_SECS, default 60, round length in seconds, legal range 1..99.
REQ-002 Parameter SCORE_W, default 7, score and high-score width in bits.
REQ-003 Parameter NUM_LEVELS, default 4, number of speed levels, legal range 2..8.
REQ-004 Parameter LEVEL_STEP, default 10, points per level step.
REQ-005 Parameter PENALTY, default 2, points subtracted on a bad-colour catch.
REQ-006 clk  in  1  system clock; sole clock of the block.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  debounced start/restart level.
REQ-009 pause  in  1  debounced pause-toggle level.
REQ-010 one_hz_tick  in  1  single-cycle pulse at 1 Hz, synchronous to clk (not a clock).
REQ-011 collision  in  1  single-cycle catch pulse.
REQ-012 color  in  2  colour of the caught item, valid when collision=1.
REQ-013 stop  out  1  high in every state except PLAY; freezes the falling and stack logic.
REQ-014 end_game  out  1  high only in OVER.
REQ-015 state  out  2  IDLE=0, PLAY=1, PAUSED=2, OVER=3.
REQ-016 sec_tens, sec_ones  out  4 each  remaining seconds as BCD.
REQ-017 score, high_score  out  SCORE_W each  current score and session best.
REQ-018 level  out  3  speed level, 0..NUM_LEVELS-1.

Function
REQ-019 The block SHALL detect rising edges of start and pause internally with one register stage each, so each press is acted on exactly once, one cycle after the edge.
REQ-020 FSM IDLE: a start edge SHALL go to PLAY, load the timer with ROUND_SECS, and clear score and level.
REQ-021 FSM PLAY: a pause edge SHALL go to PAUSED; a start edge SHALL restart (reload the timer, clear score and level, stay in PLAY); the timer reaching 0 SHALL go to OVER.
REQ-022 FSM PAUSED: a pause edge SHALL return to PLAY with the timer and score unchanged; a start edge SHALL restart as in REQ-021.
REQ-023 FSM OVER: a start edge SHALL restart as in REQ-021; pause edges SHALL be ignored.
REQ-024 If start and pause edges arrive in the same cycle, start SHALL win.
REQ-025 Timer: in PLAY only, each one_hz_tick SHALL decrement the BCD pair (ones 0 borrows from tens and sets ones to 9).
REQ-026 When the pair reaches 00, the FSM SHALL be in OVER on the next cycle; the timer SHALL never wrap below 00.
REQ-027 one_hz_tick SHALL be ignored in IDLE, PAUSED and OVER.
REQ-028 Scoring: in PLAY only, collision with colour 0/1/2 SHALL add 1/2/3 to score, saturating at 2^SCORE_W-1.
REQ-029 Colour 3 SHALL subtract PENALTY, saturating at 0.
REQ-030 Score SHALL update in the cycle after the collision pulse.
REQ-031 Collisions outside PLAY SHALL be ignored.
REQ-032 A collision in the same cycle as the final tick SHALL still be scored.
REQ-033 Level SHALL equal min(floor(score/LEVEL_STEP), NUM_LEVELS-1), registered one cycle after score, and SHALL be implemented without a divider.
REQ-034 On entry to OVER, high_score SHALL load score if score > high_score; otherwise high_score is unchanged.
REQ-035 high_score SHALL persist across restarts.
REQ-036 All outputs SHALL be registered, except that stop and end_game MAY be decoded from the state register.

Reset
REQ-037 On rst=1: state=IDLE, stop=1, end_game=0, score=0, high_score=0, level=0, and sec_tens/sec_ones = BCD of ROUND_SECS.
REQ-038 On rst=1, the edge-detect registers SHALL load the current input values so a button held through reset does not trigger.
REQ-039 rst asserted mid-round SHALL abandon the round without updating high_score.

Structure
REQ-040 State encodings, the colour-to-points table and the BCD helper constants SHALL reside in shared package game_pkg.
REQ-041 The BCD down-counter SHALL be a sub-module bcd_countdown (load, enable, tick, zero flag).
REQ-042 Everything else SHALL be flat inside game_ctrl, with stop replacing the current ad-hoc end_game|pause OR at the top level.

Verification
REQ-043 Reset, then a start edge -> state=PLAY, timer 6/0, score=0, stop=0 within 2 cycles.
REQ-044 ROUND_SECS=3, three ticks in PLAY -> timer 02, 01, 00, then state=OVER and end_game=1 the next cycle; further ticks leave the timer at 00.
REQ-045 Colours 0,1,2,3 in PLAY -> score 1,3,6,4; colour 3 at score=1 -> score 0; SCORE_W=3 at score 7 with colour 2 -> score stays 7.
REQ-046 Pause edge, 5 ticks and 2 collisions, pause edge -> timer and score unchanged, state=PLAY.
REQ-047 Round ends at score 12 -> high_score=12; restart and end at 5 -> high_score stays 12; with LEVEL_STEP=10, score 12 -> level=1.
REQ-048 Start and pause edges in the same cycle during PLAY -> restart, state=PLAY, score=0, timer reloaded.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encodings, colour scoring table and BCD helpers
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

  localparam logic [1:0] COLOR_PENALTY = 2'd3;
  localparam logic [3:0] BCD_ZERO      = 4'd0;
  localparam logic [3:0] BCD_NINE      = 4'd9;

  // Colour 3 scores nothing here; it is handled as the penalty colour.
  function automatic logic [1:0] color_points(input logic [1:0] color);
    case (color)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      2'd2:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] bcd_tens(input int secs);
    return 4'(secs / 10);
  endfunction

  function automatic logic [3:0] bcd_ones(input int secs);
    return 4'(secs % 10);
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - player inputs and display/status outputs of the game controller
interface game_ctrl_if #(
  parameter int SCORE_W = 7
);
  logic               start;
  logic               pause;
  logic               one_hz_tick;
  logic               collision;
  logic [1:0]         color;
  logic               stop;
  logic               end_game;
  logic [1:0]         state;
  logic [3:0]         sec_tens;
  logic [3:0]         sec_ones;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic [2:0]         level;

  modport master (
    output start, pause, one_hz_tick, collision, color,
    input  stop, end_game, state, sec_tens, sec_ones, score, high_score, level
  );

  modport slave (
    input  start, pause, one_hz_tick, collision, color,
    output stop, end_game, state, sec_tens, sec_ones, score, high_score, level
  );
endinterface

// File: rtl/bcd_countdown.sv
// rtl/bcd_countdown.sv - two-digit BCD down-counter that holds at 00
module bcd_countdown
  import game_pkg::*;
#(
  parameter logic [3:0] INIT_TENS = 4'd6,
  parameter logic [3:0] INIT_ONES = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       enable,
  input  logic       tick,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       zero
);
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  assign zero = (tens_q == BCD_ZERO) && (ones_q == BCD_ZERO);
  assign tens = tens_q;
  assign ones = ones_q;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load) begin
      tens_d = INIT_TENS;
      ones_d = INIT_ONES;
    end else if (enable && tick && !zero) begin
      if (ones_q == BCD_ZERO) begin
        ones_d = BCD_NINE;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q <= INIT_TENS;
      ones_q <= INIT_ONES;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end
endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - round FSM, scoring, level and high-score tracking for the catch game
module game_ctrl
  import game_pkg::*;
#(
  parameter int ROUND_SECS = 60,
  parameter int SCORE_W    = 7,
  parameter int NUM_LEVELS = 4,
  parameter int LEVEL_STEP = 10,
  parameter int PENALTY    = 2
) (
  input logic       clk,
  input logic       rst,
  game_ctrl_if.slave io
);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_e             state_q, state_d;
  logic               start_prev_q, pause_prev_q;
  logic               start_edge, pause_edge;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [2:0]         level_q, level_d;
  logic [SCORE_W:0]   score_sum;
  logic               timer_en, timer_zero;
  logic [3:0]         tens, ones;

  assign start_edge = io.start & ~start_prev_q;
  assign pause_edge = io.pause & ~pause_prev_q;
  assign timer_en   = (state_q == ST_PLAY);

  bcd_countdown #(
    .INIT_TENS(bcd_tens(ROUND_SECS)),
    .INIT_ONES(bcd_ones(ROUND_SECS))
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (start_edge),
    .enable(timer_en),
    .tick  (io.one_hz_tick),
    .tens  (tens),
    .ones  (ones),
    .zero  (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_prev_q <= io.start;
      pause_prev_q <= io.pause;
      score_q      <= '0;
      high_q       <= '0;
      level_q      <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= io.start;
      pause_prev_q <= io.pause;
      score_q      <= score_d;
      high_q       <= high_d;
      level_q      <= level_d;
    end
  end

  // Start always wins; an expired timer beats a pause in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_edge) state_d = ST_PLAY;
      ST_PLAY: begin
        if (start_edge)      state_d = ST_PLAY;
        else if (timer_zero) state_d = ST_OVER;
        else if (pause_edge) state_d = ST_PAUSED;
      end
      ST_PAUSED: if (start_edge || pause_edge) state_d = ST_PLAY;
      ST_OVER:   if (start_edge) state_d = ST_PLAY;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    io.stop     = (state_q != ST_PLAY);
    io.end_game = (state_q == ST_OVER);
    io.state    = state_q;
    io.sec_tens = tens;
    io.sec_ones = ones;
    io.score      = score_q;
    io.high_score = high_q;
    io.level      = level_q;
  end

  always_comb begin
    score_d   = score_q;
    score_sum = '0;
    if (start_edge) begin
      score_d = '0;
    end else if (state_q == ST_PLAY && io.collision) begin
      if (io.color == COLOR_PENALTY) begin
        score_d = (int'(score_q) < PENALTY) ? '0 : score_q - SCORE_W'(PENALTY);
      end else begin
        score_sum = {1'b0, score_q} + (SCORE_W+1)'(color_points(io.color));
        score_d   = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
      end
    end
  end

  // Compare against score_d so a catch on the final tick counts toward the best.
  always_comb begin
    high_d = high_q;
    if (state_d == ST_OVER && state_q != ST_OVER && score_d > high_q)
      high_d = score_d;
  end

  // Level counts the thresholds passed, avoiding a divide by LEVEL_STEP.
  always_comb begin
    level_d = '0;
    if (!start_edge) begin
      for (int k = 1; k < NUM_LEVELS; k++) begin
        if (int'(score_q) >= k * LEVEL_STEP) level_d = level_d + 3'd1;
      end
    end
  end
endmodule
